// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: FSM state encoding and default pattern seed.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'b10001010;

endpackage

// File: rtl/ram_bist_pattern.sv
// Expected-word generator: (SEED + addr) mod 2^WIDTH, bitwise inverted on the second pass.
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int          WIDTH  = 8,
  parameter int          ADDR_W = 3,
  parameter logic [31:0] SEED   = 32'(DEFAULT_SEED)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              inv,
  output logic [WIDTH-1:0]  word
);

  logic [WIDTH-1:0] base;

  always_comb begin
    base = WIDTH'(SEED) + WIDTH'(addr);
    word = inv ? ~base : base;
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style BIST controller for a single-port RAM with registered read: write/read the
// seed pattern, then its inverse, and report pass, first failing address and mismatch count.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, RAM port released
//   ST_WRITE | writing expected(i, p) to address i
//   ST_READ  | reading address i, compare tag captured for next cycle
//   ST_DRAIN | compare of last read, then second pass or finish
//   ST_DONE  | one-cycle done pulse, result valid
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter int          WIDTH  = 8,
  parameter logic [31:0] SEED   = 32'(DEFAULT_SEED),
  localparam int         ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W+1:0] fail_count,
  output logic              ram_wr_en,
  output logic [WIDTH-1:0]  ram_data_in,
  output logic [ADDR_W-1:0] ram_data_address,
  input  logic [WIDTH-1:0]  ram_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic              p;
  logic              nxt_p;
  logic              last;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [WIDTH-1:0]  cmp_tag;
  logic [WIDTH-1:0]  drive_word;
  logic [WIDTH-1:0]  tag_word;
  logic              mismatch;

  // Write data is registered, so it is generated for the address of the next cycle.
  ram_bist_pattern #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SEED(SEED)) u_drive_pat (
    .addr (nxt_addr),
    .inv  (nxt_p),
    .word (drive_word)
  );

  ram_bist_pattern #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SEED(SEED)) u_tag_pat (
    .addr (addr),
    .inv  (p),
    .word (tag_word)
  );

  assign last     = (addr == LAST_ADDR);
  assign mismatch = cmp_valid && (ram_data_out != cmp_tag);

  always_comb begin
    nxt_addr = addr + ADDR_W'(1);
    nxt_p    = p;
    case (state)
      ST_IDLE: begin
        nxt_addr = '0;
        nxt_p    = 1'b0;
      end
      ST_WRITE: if (last) nxt_addr = '0;
      ST_DRAIN: begin
        nxt_addr = '0;
        nxt_p    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      addr             <= '0;
      p                <= 1'b0;
      cmp_valid        <= 1'b0;
      cmp_addr         <= '0;
      cmp_tag          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_addr        <= '0;
      fail_count       <= '0;
      ram_wr_en        <= 1'b0;
      ram_data_in      <= '0;
      ram_data_address <= '0;
    end else begin
      done      <= 1'b0;
      cmp_valid <= 1'b0;

      if (mismatch) begin
        if (fail_count != '1) fail_count <= fail_count + 1'b1;
        if (fail_count == '0) fail_addr <= cmp_addr;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_WRITE;
            addr             <= '0;
            p                <= 1'b0;
            fail_count       <= '0;
            fail_addr        <= '0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            ram_wr_en        <= 1'b1;
            ram_data_address <= '0;
            ram_data_in      <= drive_word;
          end
        end
        ST_WRITE: begin
          addr             <= nxt_addr;
          ram_data_address <= nxt_addr;
          if (last) begin
            state       <= ST_READ;
            ram_wr_en   <= 1'b0;
            ram_data_in <= '0;
          end else begin
            ram_data_in <= drive_word;
          end
        end
        ST_READ: begin
          cmp_valid <= 1'b1;
          cmp_addr  <= addr;
          cmp_tag   <= tag_word;
          if (last) begin
            state            <= ST_DRAIN;
            addr             <= '0;
            ram_data_address <= '0;
          end else begin
            addr             <= nxt_addr;
            ram_data_address <= nxt_addr;
          end
        end
        ST_DRAIN: begin
          if (!p) begin
            state            <= ST_WRITE;
            p                <= 1'b1;
            addr             <= '0;
            ram_wr_en        <= 1'b1;
            ram_data_address <= '0;
            ram_data_in      <= drive_word;
          end else begin
            // The final compare lands this cycle, so fold it into the verdict directly.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0) && !mismatch;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
